// File: rtl/uart_tx_word_queue.sv
// uart_tx_word_queue
//   Buffers 32-bit words from the core's UART-out path in a circular FIFO and
//   feeds them, one byte at a time, to a byte-level UART sender using a
//   ready/enable handshake. The pipeline can issue back-to-back UART writes
//   while the sender is still busy.
//
// Ports
//   CLK           rising-edge clock
//   reset         synchronous, active-high
//   word_in       word to queue
//   word_enable   push strobe, sampled every rising edge
//   sender_ready  high while the byte sender is idle
//   sender_data   registered byte presented to the sender
//   sender_enable registered one-cycle start pulse to the sender
//   busy          a byte is still queued or in flight
//   full          FIFO holds 2^DEPTH_WIDTH words
//   overflow      sticky: a push was dropped
module uart_tx_word_queue #(
  parameter int DEPTH_WIDTH = 4,
  parameter bit MSB_FIRST   = 1'b1
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [31:0] word_in,
  input  logic        word_enable,
  input  logic        sender_ready,
  output logic [7:0]  sender_data,
  output logic        sender_enable,
  output logic        busy,
  output logic        full,
  output logic        overflow
);

  localparam int D = 1 << DEPTH_WIDTH;
  localparam logic [DEPTH_WIDTH:0] DEPTH = {1'b1, {DEPTH_WIDTH{1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_HOLD, S_WAIT} state_t;

  state_t                 state_q, state_d;
  logic [DEPTH_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_WIDTH:0]   count_q, count_d;
  logic [1:0]             byte_idx_q, byte_idx_d;
  logic [31:0]            word_q, word_d;
  logic [7:0]             data_q, data_d;
  logic                   en_q, en_d;
  logic                   ovf_q, ovf_d;
  logic [31:0]            mem_q [D];

  logic       pop, push;
  logic [1:0] lane;
  logic [7:0] sel_byte;

  assign full          = (count_q == DEPTH);
  assign busy          = (state_q != S_IDLE) || (count_q != '0);
  assign sender_data   = data_q;
  assign sender_enable = en_q;
  assign overflow      = ovf_q;

  // Pop only from IDLE with a word already stored: no same-edge bypass.
  assign pop  = (state_q == S_IDLE) && (count_q != '0);
  // A full FIFO still accepts a push on the edge that frees a slot.
  assign push = word_enable && (!full || pop);

  // Byte lane within the current word for this byte_idx.
  assign lane = MSB_FIRST ? (2'd3 - byte_idx_q) : byte_idx_q;

  always_comb begin
    sel_byte = word_q[7:0];
    case (lane)
      2'd0: sel_byte = word_q[7:0];
      2'd1: sel_byte = word_q[15:8];
      2'd2: sel_byte = word_q[23:16];
      2'd3: sel_byte = word_q[31:24];
      default: sel_byte = word_q[7:0];
    endcase
  end

  // FIFO bookkeeping
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q | (word_enable & ~push);
    if (push) wr_ptr_d = wr_ptr_q + DEPTH_WIDTH'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + DEPTH_WIDTH'(1);
    if (push && !pop)      count_d = count_q + (DEPTH_WIDTH+1)'(1);
    else if (pop && !push) count_d = count_q - (DEPTH_WIDTH+1)'(1);
  end

  // Byte serialiser FSM
  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    data_d     = data_q;
    en_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          word_d     = mem_q[rd_ptr_q];
          byte_idx_d = 2'd0;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (sender_ready) begin
          data_d  = sel_byte;
          en_d    = 1'b1;
          state_d = S_HOLD;
        end
      end
      // One cycle where ready is ignored so the sender can drop it.
      S_HOLD: state_d = S_WAIT;
      S_WAIT: begin
        if (sender_ready) begin
          if (byte_idx_q == 2'd3) begin
            state_d = S_IDLE;
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
            state_d    = S_ISSUE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q    <= S_IDLE;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      byte_idx_q <= 2'd0;
      word_q     <= '0;
      data_q     <= '0;
      en_q       <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
      data_q     <= data_d;
      en_q       <= en_d;
      ovf_q      <= ovf_d;
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge CLK) begin
    if (!reset && push) mem_q[wr_ptr_q] <= word_in;
  end

endmodule

// File: tb/tb_uart_tx_word_queue.sv
// Bench for uart_tx_word_queue: two instances (MSB-first and LSB-first) share
// all inputs; a behavioural byte sender answers the handshake and records
// bytes, which are compared against byte streams built from the words pushed.
module tb_uart_tx_word_queue;

  logic        CLK = 1'b0;
  logic        reset;
  logic [31:0] word_in;
  logic        word_enable;
  logic        sender_ready;
  logic        ready_m;
  logic        hold;
  logic [7:0]  d0, d1;
  logic        en0, en1, busy0, busy1, full0, full1, ovf0, ovf1;

  int n_vec = 0;
  int n_err = 0;
  int frame_len = 10;
  int cnt = 0;
  logic prev_en = 1'b0;

  logic [7:0] got0[$], got1[$], exp0[$], exp1[$];

  always #5 CLK = ~CLK;

  assign sender_ready = ready_m & ~hold;

  uart_tx_word_queue #(.DEPTH_WIDTH(4), .MSB_FIRST(1'b1)) u0 (
    .CLK(CLK), .reset(reset), .word_in(word_in), .word_enable(word_enable),
    .sender_ready(sender_ready), .sender_data(d0), .sender_enable(en0),
    .busy(busy0), .full(full0), .overflow(ovf0));

  uart_tx_word_queue #(.DEPTH_WIDTH(4), .MSB_FIRST(1'b0)) u1 (
    .CLK(CLK), .reset(reset), .word_in(word_in), .word_enable(word_enable),
    .sender_ready(sender_ready), .sender_data(d1), .sender_enable(en1),
    .busy(busy1), .full(full1), .overflow(ovf1));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Byte sender: drops ready after seeing a start pulse, raises it when the
  // frame of frame_len cycles is over.
  always @(negedge CLK) begin
    if (en0) begin
      chk("no_back_to_back_enable", {31'd0, prev_en}, 32'd0);
      chk("enable_match_lsb_inst", {31'd0, en1}, 32'd1);
      got0.push_back(d0);
      got1.push_back(d1);
      ready_m = 1'b0;
      cnt = frame_len;
    end else if (cnt > 0) begin
      cnt--;
      if (cnt == 0) ready_m = 1'b1;
    end
    prev_en = en0;
  end

  task automatic step();
    @(negedge CLK);
    #1;
  endtask

  task automatic add_exp(input logic [31:0] w);
    for (int b = 0; b < 4; b++) begin
      exp0.push_back(8'(w >> (24 - 8 * b)));
      exp1.push_back(8'(w >> (8 * b)));
    end
  endtask

  task automatic clear_q();
    got0.delete(); got1.delete(); exp0.delete(); exp1.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic drain(input string tag);
    int t = 0;
    while ((busy0 || busy1) && t < 5000) begin step(); t++; end
    chk({tag, "_timeout"}, {31'd0, (t < 5000)}, 32'd1);
    chk({tag, "_frame_done_at_idle"}, {31'd0, ready_m}, 32'd1);
    step(); step();
    chk({tag, "_nbytes_msb"}, got0.size(), exp0.size());
    chk({tag, "_nbytes_lsb"}, got1.size(), exp1.size());
    for (int i = 0; i < exp0.size() && i < got0.size(); i++)
      chk({tag, "_byte_msb"}, {24'd0, got0[i]}, {24'd0, exp0[i]});
    for (int i = 0; i < exp1.size() && i < got1.size(); i++)
      chk({tag, "_byte_lsb"}, {24'd0, got1[i]}, {24'd0, exp1[i]});
    clear_q();
  endtask

  initial begin
    logic [31:0] w;
    int t;
    reset = 1'b1; word_in = '0; word_enable = 1'b0; hold = 1'b0; ready_m = 1'b1;
    step(); step();
    reset = 1'b0;
    chk("rst_enable", {31'd0, en0}, 32'd0);
    chk("rst_data", {24'd0, d0}, 32'd0);
    chk("rst_busy", {31'd0, busy0}, 32'd0);
    chk("rst_full", {31'd0, full0}, 32'd0);
    chk("rst_overflow", {31'd0, ovf0}, 32'd0);

    // Single word with latency check: push sampled at E0, pulse after E2.
    frame_len = 10;
    word_in = 32'h41424344; word_enable = 1'b1; add_exp(32'h41424344);
    step();                               // after E0
    word_enable = 1'b0;
    chk("lat_busy_e0", {31'd0, busy0}, 32'd1);
    chk("lat_en_e0", {31'd0, en0}, 32'd0);
    step();                               // after E1 (pop)
    chk("lat_en_e1", {31'd0, en0}, 32'd0);
    step();                               // after E2
    chk("lat_en_e2", {31'd0, en0}, 32'd1);
    chk("lat_data_e2", {24'd0, d0}, 32'h41);
    drain("single");

    // Reverse-order instance sees EF BE AD DE.
    word_in = 32'hDEADBEEF; word_enable = 1'b1; add_exp(32'hDEADBEEF);
    step(); word_enable = 1'b0;
    drain("deadbeef");

    // Back-to-back pushes while the sender is slow.
    frame_len = 10;
    for (int i = 1; i <= 3; i++) begin
      word_in = i; word_enable = 1'b1; add_exp(i);
      step();
    end
    word_enable = 1'b0;
    drain("b2b");
    chk("b2b_overflow", {31'd0, ovf0}, 32'd0);

    // Randomised bursts, never more than 4 words so nothing is dropped.
    for (int r = 0; r < 6; r++) begin
      frame_len = $urandom_range(2, 12);
      for (int k = 0; k < int'($urandom_range(1, 4)); k++) begin
        repeat ($urandom_range(0, 3)) step();
        w = $urandom;
        word_in = w; word_enable = 1'b1; add_exp(w);
        step();
        word_enable = 1'b0;
      end
      drain("random");
      chk("random_overflow", {31'd0, ovf0}, 32'd0);
    end

    // Overflow: sender stalled, 18 pushes; word 0 is popped into the
    // serialiser, 16 fill the FIFO, word 17 is dropped.
    frame_len = 4;
    hold = 1'b1;
    for (int i = 0; i < 18; i++) begin
      word_in = i; word_enable = 1'b1;
      if (i <= 16) add_exp(i);
      step();
      if (i == 15) chk("ovf_full_after_15", {31'd0, full0}, 32'd0);
      if (i == 16) begin
        chk("ovf_full_after_16", {31'd0, full0}, 32'd1);
        chk("ovf_flag_after_16", {31'd0, ovf0}, 32'd0);
      end
      if (i == 17) chk("ovf_flag_after_17", {31'd0, ovf0}, 32'd1);
    end
    word_enable = 1'b0;
    hold = 1'b0;
    drain("overflow");
    chk("ovf_sticky", {31'd0, ovf0}, 32'd1);

    // Push on the pop edge while full.
    do_reset();
    chk("pp_ovf_cleared", {31'd0, ovf0}, 32'd0);
    hold = 1'b1;
    for (int i = 0; i < 17; i++) begin
      word_in = 100 + i; word_enable = 1'b1; add_exp(100 + i);
      step();
    end
    word_enable = 1'b0;
    chk("pp_full", {31'd0, full0}, 32'd1);
    hold = 1'b0;
    t = 0;
    while (got0.size() < 4 && t < 2000) begin step(); t++; end
    chk("pp_wait_4th_byte", {31'd0, (t < 2000)}, 32'd1);
    t = 0;
    while (!ready_m && t < 2000) begin step(); t++; end
    chk("pp_wait_frame", {31'd0, (t < 2000)}, 32'd1);
    step();                                // WAIT -> IDLE edge
    word_in = 32'hCAFEF00D; word_enable = 1'b1; add_exp(32'hCAFEF00D);
    step();                                // pop edge, push accepted
    word_enable = 1'b0;
    chk("pp_full_kept", {31'd0, full0}, 32'd1);
    chk("pp_no_overflow", {31'd0, ovf0}, 32'd0);
    drain("pushpop");
    chk("pp_no_overflow_end", {31'd0, ovf0}, 32'd0);

    // Reset after the second byte with three words queued.
    frame_len = 10;
    word_enable = 1'b1;
    word_in = 32'h11223344; step();
    word_in = 32'hAABBCCDD; step();
    word_in = 32'h01020304; step();
    word_enable = 1'b0;
    t = 0;
    while (got0.size() < 2 && t < 500) begin step(); t++; end
    chk("rmw_wait_2nd", {31'd0, (t < 500)}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rmw_enable", {31'd0, en0}, 32'd0);
    chk("rmw_busy", {31'd0, busy0}, 32'd0);
    chk("rmw_full", {31'd0, full0}, 32'd0);
    chk("rmw_overflow", {31'd0, ovf0}, 32'd0);
    chk("rmw_bytes_before", got0.size(), 32'd2);
    clear_q();
    repeat (40) step();
    chk("rmw_no_more_pulses", got0.size(), 32'd0);
    word_in = 32'h55667788; word_enable = 1'b1; add_exp(32'h55667788);
    step(); word_enable = 1'b0;
    drain("after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
